// File: rtl/opb_single_master_if.sv
// Command/response port and OPB master-side signals of opb_single_master.
// The master modport is the block's view; slave is the fabric/bus side.
interface opb_single_master_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_rnw;
  logic [0:C_OPB_AWIDTH-1]   cmd_addr;
  logic [0:C_OPB_DWIDTH/8-1] cmd_be;
  logic [0:C_OPB_DWIDTH-1]   cmd_data;

  logic                      rsp_valid;
  logic [0:C_OPB_DWIDTH-1]   rsp_data;
  logic                      rsp_err;
  logic                      rsp_timeout;

  logic                      M_request;
  logic                      OPB_MGrant;
  logic                      M_select;
  logic                      M_RNW;
  logic [0:C_OPB_AWIDTH-1]   M_ABus;
  logic [0:C_OPB_DWIDTH/8-1] M_BE;
  logic [0:C_OPB_DWIDTH-1]   M_DBus;
  logic                      M_seqAddr;
  logic                      M_busLock;
  logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
  logic                      OPB_xferAck;
  logic                      OPB_errAck;
  logic                      OPB_retry;
  logic                      OPB_toutSup;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_data,
    input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    output M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_data,
    output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    input  M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock
  );
endinterface

// File: rtl/opb_single_master.sv
// Single-outstanding OPB master: one fabric command -> one non-sequential OPB transfer.
// Optional transfer timeout compiled in with `define OPB_MASTER_TOUT_EN.
module opb_single_master #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_MAX_RETRY  = 8,
  parameter int C_TIMEOUT    = 16
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst,
  opb_single_master_if.master bus
);
  localparam int         LP_BEW       = C_OPB_DWIDTH / 8;
  localparam logic [7:0] LP_MAX_RETRY = 8'(C_MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_BACKOFF, S_RESP} state_t;
  state_t r_state;
  state_t w_state_next;

  logic                    r_hold_rnw;
  logic [0:C_OPB_AWIDTH-1] r_hold_addr;
  logic [0:LP_BEW-1]       r_hold_be;
  logic [0:C_OPB_DWIDTH-1] r_hold_data;
  logic [7:0]              r_retry_cnt;

  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic [0:C_OPB_DWIDTH-1] r_rsp_data;
  logic                    r_rsp_err;
  logic                    r_rsp_timeout;
  logic                    r_m_request;
  logic                    r_m_select;
  logic                    r_m_rnw;
  logic [0:C_OPB_AWIDTH-1] r_m_abus;
  logic [0:LP_BEW-1]       r_m_be;
  logic [0:C_OPB_DWIDTH-1] r_m_dbus;

  logic w_accept;
  logic w_rsp_err;
  logic w_rsp_tout;
  logic w_rd_ok;
  logic w_tout_hit;
  logic w_xfer_next;

`ifdef OPB_MASTER_TOUT_EN
  localparam logic [7:0] LP_TOUT_LAST = 8'(C_TIMEOUT - 1);
  logic [7:0] r_tout_cnt;

  // Held at zero outside XFER, so every XFER entry starts a fresh count.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst || r_state != S_XFER) begin
      r_tout_cnt <= '0;
    end else if (!bus.OPB_toutSup) begin
      r_tout_cnt <= r_tout_cnt + 8'd1;
    end
  end

  assign w_tout_hit = !bus.OPB_toutSup && (r_tout_cnt == LP_TOUT_LAST);
`else
  logic w_unused_tout;
  assign w_unused_tout = bus.OPB_toutSup | (C_TIMEOUT == 0);
  assign w_tout_hit    = 1'b0;
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_rsp_err    = 1'b0;
    w_rsp_tout   = 1'b0;
    w_rd_ok      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.OPB_MGrant) begin
          w_state_next = S_XFER;
        end
      end
      S_XFER: begin
        // errAck outranks xferAck so a simultaneous pair reports an error.
        if (bus.OPB_errAck) begin
          w_state_next = S_RESP;
          w_rsp_err    = 1'b1;
        end else if (bus.OPB_xferAck) begin
          w_state_next = S_RESP;
          w_rd_ok      = r_hold_rnw;
        end else if (bus.OPB_retry) begin
          if (r_retry_cnt == LP_MAX_RETRY) begin
            w_state_next = S_RESP;
            w_rsp_err    = 1'b1;
          end else begin
            w_state_next = S_BACKOFF;
          end
        end else if (w_tout_hit) begin
          w_state_next = S_RESP;
          w_rsp_err    = 1'b1;
          w_rsp_tout   = 1'b1;
        end
      end
      S_BACKOFF: w_state_next = S_REQ;
      S_RESP:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign w_xfer_next = (w_state_next == S_XFER);

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_hold_rnw    <= 1'b0;
      r_hold_addr   <= '0;
      r_hold_be     <= '0;
      r_hold_data   <= '0;
      r_retry_cnt   <= '0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_m_request   <= 1'b0;
      r_m_select    <= 1'b0;
      r_m_rnw       <= 1'b0;
      r_m_abus      <= '0;
      r_m_be        <= '0;
      r_m_dbus      <= '0;
    end else begin
      if (w_accept) begin
        r_hold_rnw  <= bus.cmd_rnw;
        r_hold_addr <= bus.cmd_addr;
        r_hold_be   <= bus.cmd_be;
        r_hold_data <= bus.cmd_data;
        r_retry_cnt <= '0;
      end else if (r_state == S_BACKOFF) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
      r_cmd_ready   <= (w_state_next == S_IDLE);
      r_m_request   <= (w_state_next == S_REQ);
      r_m_select    <= w_xfer_next;
      r_m_rnw       <= w_xfer_next & r_hold_rnw;
      r_m_abus      <= w_xfer_next ? r_hold_addr : '0;
      r_m_be        <= w_xfer_next ? r_hold_be : '0;
      r_m_dbus      <= (w_xfer_next && !r_hold_rnw) ? r_hold_data : '0;
      r_rsp_valid   <= (w_state_next == S_RESP);
      r_rsp_data    <= w_rd_ok ? bus.OPB_DBus : '0;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_tout;
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.M_request   = r_m_request;
  assign bus.M_select    = r_m_select;
  assign bus.M_RNW       = r_m_rnw;
  assign bus.M_ABus      = r_m_abus;
  assign bus.M_BE        = r_m_be;
  assign bus.M_DBus      = r_m_dbus;
  assign bus.M_seqAddr   = 1'b0;
  assign bus.M_busLock   = 1'b0;
endmodule

// File: tb/tb_opb_single_master.sv
// Bench for opb_single_master: directed table, mid-transfer reset and random
// commands, with the bench acting as arbiter and OPB slave.
`timescale 1ns/1ps
module tb_opb_single_master;
  localparam int C_MAX_RETRY = 8;
  localparam int C_TIMEOUT   = 16;
`ifdef OPB_MASTER_TOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;
  localparam int BUDGET = 400;
  localparam int N_TBL  = 11;
  localparam int N_RND  = 40;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          grant_dly;  // REQ cycles before grant is driven
    int          n_retry;    // attempts answered with retry
    int          ack_dly;    // XFER cycle (1-based) of final answer
    int          kind;       // final answer type
    int          sup;        // leading XFER cycles with toutSup in final attempt
    logic        exp_err;
    logic        exp_tout;
    logic [31:0] exp_data;
    int          exp_backoffs;
    int          exp_lat;    // cycles from accept edge to rsp_valid cycle
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opb_single_master_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) bus ();

  opb_single_master #(
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_MAX_RETRY (C_MAX_RETRY),
    .C_TIMEOUT   (C_TIMEOUT)
  ) dut (
    .OPB_Clk(clk),
    .OPB_Rst(rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [N_TBL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int g, input int nr, input int ad, input int kind, input int sup,
                              input logic e_err, input logic e_tout, input logic [31:0] e_data,
                              input int e_bo, input int e_lat);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.be = be; v.wdata = wdata; v.rdata = rdata;
    v.grant_dly = g; v.n_retry = nr; v.ack_dly = ad; v.kind = kind; v.sup = sup;
    v.exp_err = e_err; v.exp_tout = e_tout; v.exp_data = e_data;
    v.exp_backoffs = e_bo; v.exp_lat = e_lat;
    return v;
  endfunction

  // Reference: outcome and cycle count worked out from the bus rules directly.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int attempts, fin_x, t_tout;
    r = v;
    if (v.n_retry > C_MAX_RETRY) begin
      r.exp_backoffs = C_MAX_RETRY;
      attempts = C_MAX_RETRY + 1;
      fin_x = 1;
      r.exp_err = 1'b1;
      r.exp_tout = 1'b0;
    end else begin
      r.exp_backoffs = v.n_retry;
      attempts = v.n_retry + 1;
      t_tout = TOUT_EN ? (v.sup + C_TIMEOUT) : 1000000;
      if (v.kind != K_NONE && v.ack_dly <= t_tout) begin
        fin_x = v.ack_dly;
        r.exp_err = (v.kind != K_ACK);
        r.exp_tout = 1'b0;
      end else begin
        fin_x = t_tout;
        r.exp_err = 1'b1;
        r.exp_tout = 1'b1;
      end
    end
    r.exp_data = (!r.exp_err && v.rnw) ? v.rdata : 32'h0;
    r.exp_lat = attempts * (v.grant_dly + 1) + (attempts - 1) + fin_x + r.exp_backoffs + 1;
    return r;
  endfunction

  task automatic clear_slave();
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b0;
    bus.OPB_errAck  = 1'b0;
    bus.OPB_retry   = 1'b0;
    bus.OPB_toutSup = 1'b0;
    bus.OPB_DBus    = $urandom;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int cyc, attempts, req_cnt, xcyc, backoffs, lat, w;
    logic prev_sel;
    bit done;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_cmd", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = v.rnw;
    bus.cmd_addr  = v.addr;
    bus.cmd_be    = v.be;
    bus.cmd_data  = v.wdata;
    @(posedge clk); #1;
    chk("request_after_accept", bus.M_request, 1'b1);
    chk("ready_low_after_accept", bus.cmd_ready, 1'b0);
    attempts = 0; req_cnt = 0; xcyc = 0; backoffs = 0; lat = 0;
    prev_sel = 1'b0; done = 1'b0;
    for (cyc = 1; cyc <= BUDGET && !done; cyc++) begin
      clear_slave();
      // cmd_valid stays high with junk: nothing may be captured outside IDLE
      bus.cmd_rnw  = 1'($urandom);
      bus.cmd_addr = $urandom;
      bus.cmd_be   = 4'($urandom);
      bus.cmd_data = $urandom;
      if (bus.rsp_valid) begin
        done = 1'b1;
        lat = cyc;
        bus.cmd_valid = 1'b0;
        chk("rsp_err", bus.rsp_err, v.exp_err);
        chk("rsp_timeout", bus.rsp_timeout, v.exp_tout);
        chk("rsp_data", bus.rsp_data, v.exp_data);
        chk("select_low_at_rsp", bus.M_select, 1'b0);
        chk("ready_low_at_rsp", bus.cmd_ready, 1'b0);
      end else if (bus.M_select) begin
        if (!prev_sel) begin
          attempts++;
          xcyc = 0;
          req_cnt = 0;
        end
        xcyc++;
        chk("M_RNW", bus.M_RNW, v.rnw);
        chk("M_ABus", bus.M_ABus, v.addr);
        chk("M_BE", {28'h0, bus.M_BE}, {28'h0, v.be});
        chk("M_DBus", bus.M_DBus, v.rnw ? 32'h0 : v.wdata);
        if (attempts <= v.n_retry) begin
          bus.OPB_retry = (xcyc == 1);
        end else begin
          bus.OPB_toutSup = (xcyc <= v.sup);
          if (v.kind != K_NONE && xcyc == v.ack_dly) begin
            bus.OPB_xferAck = (v.kind == K_ACK || v.kind == K_BOTH);
            bus.OPB_errAck  = (v.kind == K_ERR || v.kind == K_BOTH);
            if (v.rnw) bus.OPB_DBus = v.rdata;
          end
        end
      end else begin
        chk("orbus_rnw", bus.M_RNW, 1'b0);
        chk("orbus_abus", bus.M_ABus, 32'h0);
        chk("orbus_be", {28'h0, bus.M_BE}, 32'h0);
        chk("orbus_dbus", bus.M_DBus, 32'h0);
        if (bus.M_request) begin
          req_cnt++;
          bus.OPB_MGrant = (req_cnt > v.grant_dly);
        end else begin
          backoffs++;
        end
      end
      prev_sel = bus.M_select;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    clear_slave();
    bus.cmd_valid = 1'b0;
    if (!done) begin
      chk("response_within_budget", 1'b0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      chk("latency", lat, v.exp_lat);
      chk("backoff_cycles", backoffs, v.exp_backoffs);
      chk("select_attempts", attempts, v.exp_backoffs + 1);
      @(posedge clk); #1;
      chk("rsp_one_cycle", bus.rsp_valid, 1'b0);
      chk("ready_after_rsp", bus.cmd_ready, 1'b1);
      chk("rsp_data_idle", bus.rsp_data, 32'h0);
      chk("rsp_err_idle", bus.rsp_err, 1'b0);
    end
    $display("txn %0d rnw=%0d addr=%08h retries=%0d kind=%0d lat=%0d backoffs=%0d err=%0d tout=%0d data=%08h",
             id, v.rnw, v.addr, v.n_retry, v.kind, lat, backoffs, v.exp_err, v.exp_tout, v.exp_data);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 32'h0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    chk({tag, "_M_request"}, bus.M_request, 1'b0);
    chk({tag, "_M_select"}, bus.M_select, 1'b0);
    chk({tag, "_M_RNW"}, bus.M_RNW, 1'b0);
    chk({tag, "_M_ABus"}, bus.M_ABus, 32'h0);
    chk({tag, "_M_BE"}, {28'h0, bus.M_BE}, 32'h0);
    chk({tag, "_M_DBus"}, bus.M_DBus, 32'h0);
    chk({tag, "_M_seqAddr"}, bus.M_seqAddr, 1'b0);
    chk({tag, "_M_busLock"}, bus.M_busLock, 1'b0);
  endtask

  initial begin
    vec_t v;
    int k;
    //                 rnw  addr          be    wdata         rdata         g  nr ad kind    sup err tout data          bo lat
    tbl[0]  = mk(1'b0, 32'h01008200, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0, 2, K_ACK,  0, 0,  0,  32'h0,        0, 4);
    tbl[1]  = mk(1'b1, 32'h01008204, 4'hF, 32'h0,        32'h12345678, 0, 0, 1, K_ACK,  0, 0,  0,  32'h12345678, 0, 3);
    tbl[2]  = mk(1'b0, 32'h01008208, 4'h3, 32'h11112222, 32'h0,        0, 3, 1, K_ACK,  0, 0,  0,  32'h0,        3, 12);
    tbl[3]  = mk(1'b1, 32'h0100820C, 4'hF, 32'h0,        32'h55AA55AA, 0, 9, 1, K_ACK,  0, 1,  0,  32'h0,        8, 27);
    tbl[4]  = mk(1'b1, 32'h01008210, 4'hF, 32'h0,        32'hCAFEF00D, 0, 0, 2, K_ERR,  0, 1,  0,  32'h0,        0, 4);
`ifdef OPB_MASTER_TOUT_EN
    tbl[5]  = mk(1'b1, 32'h01008214, 4'hF, 32'h0,        32'h0BADCAFE, 0, 0, 0, K_NONE, 0, 1,  1,  32'h0,        0, 18);
    tbl[6]  = mk(1'b0, 32'h01008218, 4'hC, 32'h5A5A0F0F, 32'h0,        0, 0, 0, K_NONE, 10,1,  1,  32'h0,        0, 28);
`else
    tbl[5]  = mk(1'b1, 32'h01008214, 4'hF, 32'h0,        32'h0BADCAFE, 0, 0, 40,K_ACK,  0, 0,  0,  32'h0BADCAFE, 0, 42);
    tbl[6]  = mk(1'b0, 32'h01008218, 4'hC, 32'h5A5A0F0F, 32'h0,        0, 0, 30,K_ACK,  10,0,  0,  32'h0,        0, 32);
`endif
    tbl[7]  = mk(1'b0, 32'h0100821C, 4'h8, 32'hA5A5A5A5, 32'h0,        0, 0, 1, K_BOTH, 0, 1,  0,  32'h0,        0, 3);
    tbl[8]  = mk(1'b1, 32'h01008220, 4'hF, 32'h0,        32'h87654321, 3, 0, 1, K_ACK,  0, 0,  0,  32'h87654321, 0, 6);
    tbl[9]  = mk(1'b1, 32'h01008224, 4'hF, 32'h0,        32'h13579BDF, 1, 8, 1, K_ACK,  0, 0,  0,  32'h13579BDF, 8, 36);
    tbl[10] = mk(1'b1, 32'h01008228, 4'hF, 32'h0,        32'h2468ACE0, 0, 0, 16,K_ACK,  0, 0,  0,  32'h2468ACE0, 0, 18);

    bus.cmd_valid = 1'b0;
    bus.cmd_rnw   = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_be    = '0;
    bus.cmd_data  = '0;
    clear_slave();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("idle");

    for (int i = 0; i < N_TBL; i++) run_txn(tbl[i], i);

    // Reset while selected: block drops the command silently
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = 1'b1;
    bus.cmd_addr  = 32'h01008300;
    bus.cmd_be    = 4'hF;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    bus.OPB_MGrant = 1'b1;
    @(posedge clk); #1;
    bus.OPB_MGrant = 1'b0;
    chk("select_before_reset", bus.M_select, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("midrst");
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_rsp_after_reset", bus.rsp_valid, 1'b0);
      chk("no_req_after_reset", bus.M_request, 1'b0);
    end
    $display("txn %0d reset during XFER, command dropped", N_TBL);
    run_txn(tbl[1], N_TBL + 1);

    for (int i = 0; i < N_RND; i++) begin
      v.rnw       = 1'($urandom_range(0, 1));
      v.addr      = $urandom;
      v.be        = 4'($urandom_range(0, 15));
      v.wdata     = $urandom;
      v.rdata     = $urandom;
      v.grant_dly = $urandom_range(0, 3);
      v.n_retry   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : 0;
      v.ack_dly   = $urandom_range(1, 20);
      k           = $urandom_range(0, 3);
      if (k == K_NONE && !TOUT_EN) k = K_ACK;
      v.kind      = k;
      v.sup       = $urandom_range(0, 6);
      v = model(v);
      run_txn(v, 100 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
